ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage pipeline. It consumes the decoded operands and control bits held by the ID/EX pipeline register and computes the ALU result, zero flag and branch target. It also runs a multi-cycle shift-add multiply for the R-type `mul` funct. Results are registered into the EX/MEM pipeline register, whose outputs this block drives. While a multiply is in progress it asserts `stall` so that IF, ID and ID/EX hold.

## Interface
- `MUL_CYCLES`, default 32: iteration count of the shift-add multiplier, one operand bit per cycle.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous; squash the current EX contents and abort any multiply.
- `reg_write, mem_to_reg, mem_write, mem_read, branch, alu_src`  in  1 each  control bits from ID/EX.
- `alu_op`  in  2  00 = add, 01 = sub, 10 = R-type (decode funct), 11 = reserved.
- `rd_in_ex`  in  5  destination register.
- `nextpc, reg_file_data1, reg_file_data2, sgn_ext_imm`  in  32 each  operands from ID/EX; funct = `sgn_ext_imm[5:0]`.
- `stall`  out  1  combinational; upstream must hold while high.
- `reg_write_out_ex_mem, mem_to_reg_out_ex_mem, mem_write_out_ex_mem, mem_read_out_ex_mem, branch_out_ex_mem`  out  1 each  registered control bits.
- `zero_out_ex_mem`  out  1  registered flag: ALU result == 0.
- `alu_result_out_ex_mem, write_data_out_ex_mem, branch_target_out_ex_mem`  out  32 each.
- `rd_out_ex_mem`  out  5.

## Operation
- Operand B = `alu_src ? sgn_ext_imm : reg_file_data2`.
- `alu_op` 00: add. 01: sub.
- `alu_op` 10, by funct:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor.
  - 0x2A slt: signed compare; result 1 or 0.
  - 0x18 mul.
  - Any other funct: result 0.
- `alu_op` 11: result 0.
- Arithmetic is modulo 2^32. Overflow is not flagged.
- `branch_target` = `nextpc + {sgn_ext_imm[29:0], 2'b00}`, modulo 2^32.
- `write_data` = `reg_file_data2`, never the immediate.
- FSM states: IDLE, MUL_BUSY, MUL_DONE.
  - IDLE, non-mul instruction: EX/MEM loads the computed results every cycle.
  - IDLE, mul detected (`alu_op`=10, funct 0x18): latch A, B, rd and controls; clear the accumulator and counter; go to MUL_BUSY. EX/MEM loads a bubble.
  - MUL_BUSY: each cycle, if multiplier bit[0] is set, add the multiplicand to the accumulator. Shift the multiplicand left and the multiplier right. Increment the counter. EX/MEM holds a bubble. After iteration `MUL_CYCLES-1`, go to MUL_DONE.
  - MUL_DONE: EX/MEM loads the accumulator (low 32 bits of the product, same for signed and unsigned), the latched rd and the latched controls. `zero` reflects the product. Go to IDLE. ID/EX inputs are ignored in this cycle.
- Bubble: all five control outputs are 0. Data outputs are don't-care but must be deterministic; hold the previous value.
- `stall` = (IDLE and mul detected) or MUL_BUSY. It is low in MUL_DONE, so ID/EX advances on the same edge that EX/MEM captures the product.

## Timing
- Non-mul latency: 1 cycle; results appear after the edge that samples the ID/EX outputs.
- Mul, presented to EX in cycle 0:
  - `stall` is high in cycles 0 to 32, 33 cycles in total.
  - MUL_DONE is cycle 33.
  - The product is visible in EX/MEM after the edge ending cycle 33.
- Back-to-back mul: the second mul is detected in IDLE on the cycle after MUL_DONE. No lost or duplicated issue.
- `flush` (sampled at the edge) has priority over everything except reset:
  - EX/MEM loads a bubble.
  - The FSM returns to IDLE.
  - `stall` drops in the next cycle.
  - A mul present in IDLE together with `flush` is not started.
- Reset low at an edge:
  - All outputs clear to 0: control bits, zero, data, rd.
  - The FSM goes to IDLE and the counter and accumulator clear.
  - This applies mid-multiply too.
  - `stall` is 0 while the FSM is in IDLE with `alu_op` ≠ 10.
- Reset beats flush. Flush beats MUL_DONE completion.

## Structure
- Shared package: `alu_op` encodings, funct codes (ADD, SUB, AND, OR, NOR, SLT, MUL), FSM state enum, `MUL_CYCLES` default.
- One sub-module, `shift_add_mul`: start/done handshake, operand latches, counter, accumulator.
- ALU, branch adder and EX/MEM registers stay in `ex_stage`.

## Test plan
- add: data1 = 5, data2 = 7, `alu_op`=10, funct 0x20 → `alu_result` = 12, `zero` = 0 after 1 edge. `stall` stays 0.
- beq: `alu_op`=01, data1 = data2 = 0x1234, imm = 4, nextpc = 0x100, branch = 1 → `zero` = 1, `branch_target` = 0x110, `branch_out` = 1.
- lw: `alu_op`=00, `alu_src` = 1, data1 = 0x1000, imm = 0xFFFFFFF8 → `alu_result` = 0xFF8, `mem_read_out` = 1, `write_data` = data2.
- mul: 7 × 6, rd = 9 → `stall` high exactly 33 cycles. Bubbles during that time. `alu_result` = 42, rd = 9, `reg_write` = 1 after the 34th edge. Repeat with 0xFFFFFFFD × 5 → 0xFFFFFFF1.
- flush at MUL_BUSY iteration 10 → bubble next edge, `stall` 0 in the next cycle, FSM in IDLE, no product written. Reset low at iteration 20 → all outputs 0 and `stall` 0 after the edge.
- slt: -1 vs 1 → `alu_result` = 1. Unknown funct 0x3F → `alu_result` = 0, `zero` = 1.

Source files
------------

// File: rtl/ex_stage_pkg.sv
//------------------------------------------------------------------------------
// Module   : ex_stage_pkg
// Brief    : Shared encodings for the execute stage: alu_op codes, R-type funct
//            codes, multiplier FSM states and EX/MEM control bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ex_stage_pkg;

  // Default number of shift-add iterations (one multiplier bit per cycle).
  localparam int MUL_CYCLES_DEF = 32;

  // alu_op encodings driven by the decoder.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_RSVD  = 2'b11;

  // R-type funct codes (sgn_ext_imm[5:0]).
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  // Multiplier sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_MUL_DONE = 2'd2
  } mul_state_e;

  // Control bits carried into EX/MEM; all-zero is a bubble.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic mem_read;
    logic branch;
  } ex_ctl_t;

endpackage

`default_nettype wire

// File: rtl/ex_stage_shift_add_mul.sv
//------------------------------------------------------------------------------
// Module   : shift_add_mul
// Brief    : Iterative shift-add multiplier producing the low 32 bits of a*b.
//            start_i in IDLE latches the operands, MUL_CYCLES iterations follow,
//            then one MUL_DONE cycle presents the product. flush_i aborts.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_add_mul
  import ex_stage_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        idle_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o
);

  localparam int              CNT_W     = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_CYCLES - 1);

  mul_state_e       state_q, state_d;
  logic [31:0]      mcand_q;
  logic [31:0]      mplier_q;
  logic [31:0]      acc_q;
  logic [CNT_W-1:0] cnt_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: flush aborts from any state; a start in IDLE launches a run.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (start_i) state_d = ST_MUL_BUSY;
        ST_MUL_BUSY: if (cnt_q == LAST_ITER) state_d = ST_MUL_DONE;
        ST_MUL_DONE: state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Operand latches, counter and accumulator; one multiplier bit per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == ST_IDLE && start_i && !flush_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == ST_MUL_BUSY) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= {mcand_q[30:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[31:1]};
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign idle_o    = (state_q == ST_IDLE);
  assign busy_o    = (state_q == ST_MUL_BUSY);
  assign done_o    = (state_q == ST_MUL_DONE);
  assign product_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
//------------------------------------------------------------------------------
// Module   : ex_stage
// Brief    : Execute stage: ALU, branch-target adder, multi-cycle multiply
//            sequencing and the EX/MEM pipeline register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic        branch,
  input  logic        alu_src,
  input  logic [1:0]  alu_op,
  input  logic [4:0]  rd_in_ex,
  input  logic [31:0] nextpc,
  input  logic [31:0] reg_file_data1,
  input  logic [31:0] reg_file_data2,
  input  logic [31:0] sgn_ext_imm,
  output logic        stall,
  output logic        reg_write_out_ex_mem,
  output logic        mem_to_reg_out_ex_mem,
  output logic        mem_write_out_ex_mem,
  output logic        mem_read_out_ex_mem,
  output logic        branch_out_ex_mem,
  output logic        zero_out_ex_mem,
  output logic [31:0] alu_result_out_ex_mem,
  output logic [31:0] write_data_out_ex_mem,
  output logic [31:0] branch_target_out_ex_mem,
  output logic [4:0]  rd_out_ex_mem
);

  logic [5:0]  funct;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] br_target;
  logic        mul_det;
  ex_ctl_t     ctl_in;

  logic        mul_idle, mul_busy, mul_done;
  logic [31:0] mul_product;

  ex_ctl_t     mul_ctl_q;
  logic [4:0]  mul_rd_q;

  ex_ctl_t     ctl_q,  ctl_d;
  logic        zero_q, zero_d;
  logic [31:0] alu_q,  alu_d;
  logic [31:0] wd_q,   wd_d;
  logic [31:0] bt_q,   bt_d;
  logic [4:0]  rd_q,   rd_d;

  assign funct     = sgn_ext_imm[5:0];
  assign op_b      = alu_src ? sgn_ext_imm : reg_file_data2;
  assign br_target = nextpc + {sgn_ext_imm[29:0], 2'b00};
  assign mul_det   = (alu_op == ALU_OP_RTYPE) && (funct == FUNCT_MUL);
  assign ctl_in    = {reg_write, mem_to_reg, mem_write, mem_read, branch};

  // Single-cycle ALU; mul and any undefined encoding yield 0 here.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_OP_ADD: alu_res = reg_file_data1 + op_b;
      ALU_OP_SUB: alu_res = reg_file_data1 - op_b;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_res = reg_file_data1 + op_b;
          FUNCT_SUB: alu_res = reg_file_data1 - op_b;
          FUNCT_AND: alu_res = reg_file_data1 & op_b;
          FUNCT_OR:  alu_res = reg_file_data1 | op_b;
          FUNCT_NOR: alu_res = ~(reg_file_data1 | op_b);
          FUNCT_SLT: alu_res = {31'b0, $signed(reg_file_data1) < $signed(op_b)};
          default:   alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  shift_add_mul #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush),
    .start_i   (mul_det),
    .a_i       (reg_file_data1),
    .b_i       (op_b),
    .idle_o    (mul_idle),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Hold upstream from mul detection until the product cycle.
  assign stall = (mul_idle && mul_det) || mul_busy;

  // Capture destination and controls of the mul so they survive the stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mul_ctl_q <= '0;
      mul_rd_q  <= '0;
    end else if (mul_idle && mul_det && !flush) begin
      mul_ctl_q <= ctl_in;
      mul_rd_q  <= rd_in_ex;
    end
  end

  // EX/MEM next value: bubble by default with data held; flush wins over all.
  always_comb begin
    ctl_d  = '0;
    zero_d = zero_q;
    alu_d  = alu_q;
    wd_d   = wd_q;
    bt_d   = bt_q;
    rd_d   = rd_q;
    if (flush) begin
      ctl_d = '0;
    end else if (mul_done) begin
      ctl_d  = mul_ctl_q;
      alu_d  = mul_product;
      zero_d = (mul_product == 32'd0);
      rd_d   = mul_rd_q;
    end else if (mul_idle && !mul_det) begin
      ctl_d  = ctl_in;
      alu_d  = alu_res;
      zero_d = (alu_res == 32'd0);
      wd_d   = reg_file_data2;
      bt_d   = br_target;
      rd_d   = rd_in_ex;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctl_q  <= '0;
      zero_q <= 1'b0;
      alu_q  <= '0;
      wd_q   <= '0;
      bt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctl_q  <= ctl_d;
      zero_q <= zero_d;
      alu_q  <= alu_d;
      wd_q   <= wd_d;
      bt_q   <= bt_d;
      rd_q   <= rd_d;
    end
  end

  assign reg_write_out_ex_mem     = ctl_q.reg_write;
  assign mem_to_reg_out_ex_mem    = ctl_q.mem_to_reg;
  assign mem_write_out_ex_mem     = ctl_q.mem_write;
  assign mem_read_out_ex_mem      = ctl_q.mem_read;
  assign branch_out_ex_mem        = ctl_q.branch;
  assign zero_out_ex_mem          = zero_q;
  assign alu_result_out_ex_mem    = alu_q;
  assign write_data_out_ex_mem    = wd_q;
  assign branch_target_out_ex_mem = bt_q;
  assign rd_out_ex_mem            = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_ex_stage
// Brief    : Directed bench for ex_stage with a cycle-tagged scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        reg_write, mem_to_reg, mem_write, mem_read, branch, alu_src;
  logic [1:0]  alu_op;
  logic [4:0]  rd_in_ex;
  logic [31:0] nextpc, reg_file_data1, reg_file_data2, sgn_ext_imm;
  logic        stall;
  logic        reg_write_out_ex_mem, mem_to_reg_out_ex_mem, mem_write_out_ex_mem;
  logic        mem_read_out_ex_mem, branch_out_ex_mem, zero_out_ex_mem;
  logic [31:0] alu_result_out_ex_mem, write_data_out_ex_mem, branch_target_out_ex_mem;
  logic [4:0]  rd_out_ex_mem;

  ex_stage dut (
    .clk                      (clk),
    .reset                    (reset),
    .flush                    (flush),
    .reg_write                (reg_write),
    .mem_to_reg               (mem_to_reg),
    .mem_write                (mem_write),
    .mem_read                 (mem_read),
    .branch                   (branch),
    .alu_src                  (alu_src),
    .alu_op                   (alu_op),
    .rd_in_ex                 (rd_in_ex),
    .nextpc                   (nextpc),
    .reg_file_data1           (reg_file_data1),
    .reg_file_data2           (reg_file_data2),
    .sgn_ext_imm              (sgn_ext_imm),
    .stall                    (stall),
    .reg_write_out_ex_mem     (reg_write_out_ex_mem),
    .mem_to_reg_out_ex_mem    (mem_to_reg_out_ex_mem),
    .mem_write_out_ex_mem     (mem_write_out_ex_mem),
    .mem_read_out_ex_mem      (mem_read_out_ex_mem),
    .branch_out_ex_mem        (branch_out_ex_mem),
    .zero_out_ex_mem          (zero_out_ex_mem),
    .alu_result_out_ex_mem    (alu_result_out_ex_mem),
    .write_data_out_ex_mem    (write_data_out_ex_mem),
    .branch_target_out_ex_mem (branch_target_out_ex_mem),
    .rd_out_ex_mem            (rd_out_ex_mem)
  );

  always #5 clk = ~clk;

  // Cycle index: advances on every rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          is_stall;
    bit          stall;
    logic [4:0]  ctl;
    bit          chk_alu;
    logic [31:0] alu;
    logic        zero;
    logic [4:0]  rd;
    bit          chk_wb;
    logic [31:0] wd;
    logic [31:0] bt;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void push_stall(int c, bit s, string nm);
    exp_t e;
    e.cyc = c; e.is_stall = 1'b1; e.stall = s; e.ctl = '0;
    e.chk_alu = 1'b0; e.alu = '0; e.zero = 1'b0; e.rd = '0;
    e.chk_wb = 1'b0; e.wd = '0; e.bt = '0; e.name = nm;
    sb.push_back(e);
  endfunction

  function automatic void push_out(int c, logic [4:0] ctl, bit ca, logic [31:0] alu,
                                   logic zero, logic [4:0] rd, bit cw, logic [31:0] wd,
                                   logic [31:0] bt, string nm);
    exp_t e;
    e.cyc = c; e.is_stall = 1'b0; e.stall = 1'b0; e.ctl = ctl;
    e.chk_alu = ca; e.alu = alu; e.zero = zero; e.rd = rd;
    e.chk_wb = cw; e.wd = wd; e.bt = bt; e.name = nm;
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation tagged with the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        exp_t e;
        bit   ok;
        logic [4:0] act_ctl;
        e = sb[i];
        act_ctl = {reg_write_out_ex_mem, mem_to_reg_out_ex_mem, mem_write_out_ex_mem,
                   mem_read_out_ex_mem, branch_out_ex_mem};
        n_checks++;
        if (e.is_stall) begin
          ok = (stall === e.stall);
        end else begin
          ok = (act_ctl === e.ctl);
          if (e.chk_alu)
            ok = ok && (alu_result_out_ex_mem === e.alu) && (zero_out_ex_mem === e.zero)
                    && (rd_out_ex_mem === e.rd);
          if (e.chk_wb)
            ok = ok && (write_data_out_ex_mem === e.wd) && (branch_target_out_ex_mem === e.bt);
        end
        if (e.cyc < cyc) ok = 1'b0;
        if (ok) begin
          n_pass++;
        end else if (e.is_stall) begin
          $display("FAIL %s cyc=%0d: stall=%b required %b", e.name, e.cyc, stall, e.stall);
        end else begin
          $display("FAIL %s cyc=%0d: got ctl=%b alu=%h z=%b rd=%0d wd=%h bt=%h required ctl=%b alu=%h z=%b rd=%0d wd=%h bt=%h (alu chk %0b, wb chk %0b)",
                   e.name, e.cyc, act_ctl, alu_result_out_ex_mem, zero_out_ex_mem,
                   rd_out_ex_mem, write_data_out_ex_mem, branch_target_out_ex_mem,
                   e.ctl, e.alu, e.zero, e.rd, e.wd, e.bt, e.chk_alu, e.chk_wb);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [4:0] ctl, logic [1:0] op, logic src, logic [4:0] rd,
                       logic [31:0] npc, logic [31:0] d1, logic [31:0] d2, logic [31:0] imm);
    {reg_write, mem_to_reg, mem_write, mem_read, branch} = ctl;
    alu_op = op; alu_src = src; rd_in_ex = rd; nextpc = npc;
    reg_file_data1 = d1; reg_file_data2 = d2; sgn_ext_imm = imm;
  endtask

  // One non-mul instruction: stall low now, results one edge later.
  task automatic nonmul(string nm, logic [4:0] ctl, logic [1:0] op, logic src, logic [4:0] rd,
                        logic [31:0] npc, logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
                        logic [31:0] ealu, logic ez, logic [31:0] ebt);
    drive(ctl, op, src, rd, npc, d1, d2, imm);
    push_stall(cyc, 1'b0, {nm, "_stall"});
    push_out(cyc + 1, ctl, 1'b1, ealu, ez, rd, 1'b1, d2, ebt, nm);
    step();
  endtask

  // Full mul: 33 stall cycles, bubbles, then product on the 34th edge.
  task automatic mul_run(string nm, logic [4:0] rd, logic [31:0] a, logic [31:0] b,
                         logic [31:0] prod, logic ez);
    int c0;
    drive(5'b10000, 2'b10, 1'b0, rd, 32'h0, a, b, 32'h18);
    c0 = cyc;
    for (int k = 0; k <= 32; k++) push_stall(c0 + k, 1'b1, {nm, "_stall_hi"});
    push_stall(c0 + 33, 1'b0, {nm, "_stall_done"});
    for (int k = 1; k <= 33; k++)
      push_out(c0 + k, 5'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, {nm, "_bubble"});
    push_out(c0 + 34, 5'b10000, 1'b1, prod, ez, rd, 1'b0, '0, '0, nm);
    repeat (34) step();
  endtask

  initial begin
    int c0;
    reset = 1'b0; flush = 1'b0;
    drive(5'b0, 2'b00, 1'b0, 5'd0, '0, '0, '0, '0);
    step(); step();
    push_out(cyc, 5'b0, 1'b1, '0, 1'b0, '0, 1'b1, '0, '0, "reset_state");
    push_stall(cyc, 1'b0, "reset_stall");
    reset = 1'b1;

    nonmul("add",  5'b10000, 2'b10, 1'b0, 5'd3, 32'h4,   32'd5,      32'd7,      32'h20,       32'd12,       1'b0, 32'h84);
    nonmul("beq",  5'b00001, 2'b01, 1'b0, 5'd0, 32'h100, 32'h1234,   32'h1234,   32'h4,        32'h0,        1'b1, 32'h110);
    nonmul("lw",   5'b11010, 2'b00, 1'b1, 5'd8, 32'h200, 32'h1000,   32'hABCD,   32'hFFFFFFF8, 32'hFF8,      1'b0, 32'h1E0);
    nonmul("sub",  5'b10000, 2'b10, 1'b0, 5'd4, 32'h0,   32'd10,     32'd3,      32'h22,       32'd7,        1'b0, 32'h88);
    nonmul("and",  5'b10000, 2'b10, 1'b0, 5'd5, 32'h0,   32'hF0F0,   32'hFF00,   32'h24,       32'hF000,     1'b0, 32'h90);
    nonmul("or",   5'b10000, 2'b10, 1'b0, 5'd6, 32'h0,   32'hF0F0,   32'h0F0F,   32'h25,       32'hFFFF,     1'b0, 32'h94);
    nonmul("nor",  5'b10000, 2'b10, 1'b0, 5'd7, 32'h0,   32'h0,      32'h0,      32'h27,       32'hFFFFFFFF, 1'b0, 32'h9C);
    nonmul("slt",  5'b10000, 2'b10, 1'b0, 5'd2, 32'h0,   32'hFFFFFFFF, 32'd1,    32'h2A,       32'd1,        1'b0, 32'hA8);
    nonmul("sltn", 5'b10000, 2'b10, 1'b0, 5'd2, 32'h0,   32'd1,      32'hFFFFFFFF, 32'h2A,     32'd0,        1'b1, 32'hA8);
    nonmul("unk",  5'b10000, 2'b10, 1'b0, 5'd2, 32'h0,   32'd5,      32'd3,      32'h3F,       32'd0,        1'b1, 32'hFC);
    nonmul("rsvd", 5'b10000, 2'b11, 1'b0, 5'd2, 32'h0,   32'd5,      32'd3,      32'h20,       32'd0,        1'b1, 32'h80);
    nonmul("sw",   5'b00100, 2'b00, 1'b1, 5'd0, 32'h0,   32'h40,     32'h55,     32'h8,        32'h48,       1'b0, 32'h20);

    mul_run("mul7x6", 5'd9,  32'd7,        32'd5 + 32'd1, 32'd42,       1'b0);
    mul_run("mulneg", 5'd10, 32'hFFFFFFFD, 32'd5,         32'hFFFFFFF1, 1'b0);
    nonmul("add_after", 5'b10000, 2'b10, 1'b0, 5'd1, 32'h0, 32'd1, 32'd2, 32'h20, 32'd3, 1'b0, 32'h80);

    // Flush at multiply iteration 10.
    drive(5'b10000, 2'b10, 1'b0, 5'd11, 32'h0, 32'd3, 32'd3, 32'h18);
    c0 = cyc;
    for (int k = 0; k <= 11; k++) push_stall(c0 + k, 1'b1, "fl_stall_hi");
    for (int k = 1; k <= 11; k++)
      push_out(c0 + k, 5'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, "fl_bubble");
    repeat (11) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(5'b0, 2'b00, 1'b0, 5'd0, '0, '0, '0, '0);
    push_stall(c0 + 12, 1'b0, "fl_stall_drop");
    push_out(c0 + 12, 5'b0, 1'b1, 32'd3, 1'b0, 5'd1, 1'b1, 32'd2, 32'h80, "fl_bubble_hold");
    push_out(c0 + 13, 5'b0, 1'b1, 32'd0, 1'b1, 5'd0, 1'b1, '0, '0, "fl_nop");
    push_stall(c0 + 40, 1'b0, "fl_idle_late");
    push_out(c0 + 40, 5'b0, 1'b1, 32'd0, 1'b1, 5'd0, 1'b1, '0, '0, "fl_no_product");
    repeat (30) step();

    // Reset asserted at multiply iteration 20.
    nonmul("add_pre", 5'b10000, 2'b10, 1'b0, 5'd3, 32'h4, 32'd5, 32'd7, 32'h20, 32'd12, 1'b0, 32'h84);
    drive(5'b10000, 2'b10, 1'b0, 5'd12, 32'h0, 32'd3, 32'd3, 32'h18);
    c0 = cyc;
    for (int k = 0; k <= 21; k++) push_stall(c0 + k, 1'b1, "rs_stall_hi");
    for (int k = 1; k <= 21; k++)
      push_out(c0 + k, 5'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, "rs_bubble");
    repeat (21) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    drive(5'b0, 2'b00, 1'b0, 5'd0, '0, '0, '0, '0);
    push_stall(c0 + 22, 1'b0, "rs_stall_low");
    push_out(c0 + 22, 5'b0, 1'b1, '0, 1'b0, '0, 1'b1, '0, '0, "rs_clear");
    push_out(c0 + 23, 5'b0, 1'b1, '0, 1'b1, '0, 1'b1, '0, '0, "rs_nop");
    push_out(c0 + 50, 5'b0, 1'b1, '0, 1'b1, '0, 1'b1, '0, '0, "rs_no_product");
    repeat (30) step();

    // Mul presented together with flush in IDLE must not start.
    drive(5'b10000, 2'b10, 1'b0, 5'd13, 32'h0, 32'd4, 32'd4, 32'h18);
    flush = 1'b1;
    c0 = cyc;
    step();
    flush = 1'b0;
    drive(5'b0, 2'b00, 1'b0, 5'd0, '0, '0, '0, '0);
    push_stall(c0 + 1, 1'b0, "fi_stall_low");
    push_out(c0 + 1, 5'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, "fi_bubble");
    push_out(c0 + 2, 5'b0, 1'b1, '0, 1'b1, '0, 1'b1, '0, '0, "fi_nop");
    push_stall(c0 + 35, 1'b0, "fi_idle_late");
    push_out(c0 + 36, 5'b0, 1'b1, '0, 1'b1, '0, 1'b1, '0, '0, "fi_no_product");
    repeat (40) step();

    repeat (3) step();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      n_checks += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
